// File: rtl/mult_pkg.sv
// mult_pkg: shared types and sizes for the multiply arbiter/controller.
// Holds the controller state encoding, operand width, iteration count
// and requester count used by mult_arbiter_ctrl and mult_rr_arb.

package mult_pkg;

    localparam int OP_WIDTH   = 8;
    localparam int ITER_COUNT = 8;
    localparam int REQ_COUNT  = 2;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    // Last shift-add iteration: the multiplier sign bit is handled here.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        ADDSUB,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/mult_rr_arb.sv
// mult_rr_arb: picks one requester for the shared multiplier.
// Build option MULT_ARB_ROUND_ROBIN_EN: when defined, the requester that
// last completed becomes lowest priority; when undefined, requester 0
// always wins and no pointer state exists.

module mult_rr_arb
    import mult_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [REQ_COUNT-1:0] i_req,
    input  logic                 i_advance,
    input  logic [REQ_COUNT-1:0] i_owner,
    output logic [REQ_COUNT-1:0] o_winner
);

`ifdef MULT_ARB_ROUND_ROBIN_EN
    // Set when requester 1 holds priority over requester 0.
    logic r_ptr;

    // Hand priority to the requester that did not just finish.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= i_owner[0];
        end
    end

    // Grant the prioritised requester first, otherwise whoever asks.
    always_comb begin
        // NOTE: default first so every path assigns o_winner and no latch is inferred.
        o_winner = '0;
        if (r_ptr && i_req[1]) begin
            o_winner = 2'b10;
        end else if (i_req[0]) begin
            o_winner = 2'b01;
        end else if (i_req[1]) begin
            o_winner = 2'b10;
        end
    end
`else
    // Fixed priority has no state; these inputs are intentionally ignored.
    wire w_unused = &{1'b0, Clk, Reset, i_advance, i_owner};

    // Requester 0 always wins a simultaneous request.
    always_comb begin
        // NOTE: default first so every path assigns o_winner and no latch is inferred.
        o_winner = '0;
        if (i_req[0]) begin
            o_winner = 2'b01;
        end else if (i_req[1]) begin
            o_winner = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/mult_arbiter_ctrl.sv
// mult_arbiter_ctrl: shares one external shift-add signed multiplier
// datapath between two requesters. Sequence per job:
// LOAD, CLEAR, 8 x (ADDSUB, SHIFT), DONE = 19 cycles.
// Build option MULT_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// in mult_rr_arb; undefined gives fixed priority to requester 0.

module mult_arbiter_ctrl
    import mult_pkg::*;
(
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [REQ_COUNT-1:0]    req,
    input  logic [OP_WIDTH-1:0]     opa0,
    input  logic [OP_WIDTH-1:0]     opa1,
    input  logic [OP_WIDTH-1:0]     opb0,
    input  logic [OP_WIDTH-1:0]     opb1,
    input  logic                    M,
    input  logic [OP_WIDTH-1:0]     Aval,
    input  logic [OP_WIDTH-1:0]     Bval,
    output logic [REQ_COUNT-1:0]    gnt,
    output logic [OP_WIDTH-1:0]     Din_S,
    output logic [OP_WIDTH-1:0]     Din_B,
    output logic                    Ld_SB,
    output logic                    Clr_XA,
    output logic                    Add,
    output logic                    Sub,
    output logic                    Shift,
    output logic [REQ_COUNT-1:0]    done,
    output logic [2*OP_WIDTH-1:0]   product
);

    state_t                  r_state;
    state_t                  w_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [REQ_COUNT-1:0]    r_owner;
    logic [OP_WIDTH-1:0]     r_opa;
    logic [OP_WIDTH-1:0]     r_opb;
    logic [2*OP_WIDTH-1:0]   r_product;
    logic [REQ_COUNT-1:0]    w_winner;
    logic                    w_advance;
    logic                    w_start;

    assign w_advance = (r_state == DONE);
    assign w_start   = (r_state == IDLE) && (|req);

    mult_rr_arb u_arb (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_req     (req),
        .i_advance (w_advance),
        .i_owner   (r_owner),
        .o_winner  (w_winner)
    );

    // Grant is held from LOAD through DONE; done pulses only in DONE.
    assign gnt     = (r_state != IDLE) ? r_owner : '0;
    assign done    = w_advance ? r_owner : '0;
    assign Din_S   = r_opa;
    assign Din_B   = r_opb;
    assign product = r_product;

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and datapath strobes; at most one strobe per state.
    always_comb begin
        w_next = r_state;
        Ld_SB  = 1'b0;
        Clr_XA = 1'b0;
        Add    = 1'b0;
        Sub    = 1'b0;
        Shift  = 1'b0;
        case (r_state)
            IDLE:   if (|req) w_next = LOAD;
            LOAD: begin
                Ld_SB  = 1'b1;
                w_next = CLEAR;
            end
            CLEAR: begin
                Clr_XA = 1'b1;
                w_next = ADDSUB;
            end
            ADDSUB: begin
                // Multiplier sign bit carries negative weight: subtract on the last step.
                Add    = M && (r_cnt != LAST_ITER);
                Sub    = M && (r_cnt == LAST_ITER);
                w_next = SHIFT;
            end
            SHIFT: begin
                Shift  = 1'b1;
                w_next = (r_cnt == LAST_ITER) ? DONE : ADDSUB;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Owner/operand capture at start, iteration counter, result capture in DONE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_owner   <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            if (w_start) begin
                r_owner <= w_winner;
                r_opa   <= w_winner[1] ? opa1 : opa0;
                r_opb   <= w_winner[1] ? opb1 : opb0;
            end
            if (r_state == CLEAR) begin
                r_cnt <= '0;
            end else if ((r_state == SHIFT) && (r_cnt != LAST_ITER)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == DONE) begin
                r_product <= {Aval, Bval};
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter_ctrl.sv
// tb_mult_arbiter_ctrl: bench for mult_arbiter_ctrl with a behavioural
// model of the external signed shift-add datapath (S, X, A, B registers).
// Expected completions are queued by the stimulus and popped by a monitor
// whenever done is seen. Honours MULT_ARB_ROUND_ROBIN_EN for expectations.

module tb_mult_arbiter_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [1:0]  req;
    logic [7:0]  opa0, opa1, opb0, opb1;
    logic        M;
    logic [7:0]  Aval, Bval;
    logic [1:0]  gnt;
    logic [7:0]  Din_S, Din_B;
    logic        Ld_SB, Clr_XA, Add, Sub, Shift;
    logic [1:0]  done;
    logic [15:0] product;

    typedef struct {
        logic [1:0]  who;
        logic [15:0] prod;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          add_seen = 0;
    int          sub_seen = 0;

    always #5 Clk = ~Clk;

    mult_arbiter_ctrl dut (
        .Clk(Clk), .Reset(Reset), .req(req),
        .opa0(opa0), .opa1(opa1), .opb0(opb0), .opb1(opb1),
        .M(M), .Aval(Aval), .Bval(Bval),
        .gnt(gnt), .Din_S(Din_S), .Din_B(Din_B),
        .Ld_SB(Ld_SB), .Clr_XA(Clr_XA), .Add(Add), .Sub(Sub), .Shift(Shift),
        .done(done), .product(product)
    );

    // External datapath model: {X,A} accumulates, {X,A,B} shifts right arithmetically.
    logic [7:0] dp_s, dp_a, dp_b;
    logic       dp_x;
    assign M    = dp_b[0];
    assign Aval = dp_a;
    assign Bval = dp_b;

    always @(posedge Clk) begin
        if (Reset) begin
            dp_s <= '0; dp_a <= '0; dp_b <= '0; dp_x <= 1'b0;
        end else if (Ld_SB) begin
            dp_s <= Din_S;
            dp_b <= Din_B;
        end else if (Clr_XA) begin
            dp_a <= '0;
            dp_x <= 1'b0;
        end else if (Add) begin
            {dp_x, dp_a} <= {dp_x, dp_a} + {dp_s[7], dp_s};
        end else if (Sub) begin
            {dp_x, dp_a} <= {dp_x, dp_a} - {dp_s[7], dp_s};
        end else if (Shift) begin
            dp_a <= {dp_x, dp_a[7:1]};
            dp_b <= {dp_a[0], dp_b[7:1]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
        end
    endtask

    // Monitor: latency of grant, done/owner/product against scoreboard, one-hot rules.
    int          lat = 0;
    bit          prod_pending = 1'b0;
    logic [15:0] prod_exp;

    always @(negedge Clk) begin
        exp_t e;
        if (prod_pending) begin
            check("product", 32'(product), 32'(prod_exp));
            prod_pending = 1'b0;
        end
        if (Reset) begin
            lat = 0;
        end else begin
            if (gnt != 2'b00) lat++; else lat = 0;
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_owner", 32'(done), 32'(e.who));
                    check("gnt_at_done", 32'(gnt), 32'(e.who));
                    check("latency", 32'(lat), 32'd19);
                    prod_exp     = e.prod;
                    prod_pending = 1'b1;
                end
            end
            add_seen += int'(Add);
            sub_seen += int'(Sub);
        end
        total += 2;
        a_strobe: assert ($onehot0({Ld_SB, Clr_XA, Add, Sub, Shift})) else begin
            bad++;
            $display("FAIL strobe_onehot0: got %b expected at most one set",
                     {Ld_SB, Clr_XA, Add, Sub, Shift});
        end
        a_gnt: assert ($onehot0(gnt)) else begin
            bad++;
            $display("FAIL gnt_onehot0: got %b expected at most one set", gnt);
        end
    end

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge Clk);
            if (done != 2'b00) seen = 1'b1;
        end
        if (!seen) check({tag, "_done_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_gnt(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge Clk);
            if (gnt != 2'b00) seen = 1'b1;
        end
        if (!seen) check({tag, "_gnt_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic push(input logic [1:0] who, input logic [15:0] prod);
        exp_t e;
        e.who  = who;
        e.prod = prod;
        sb.push_back(e);
    endtask

    initial begin
        int a0, s0;
        logic [1:0] second_who, third_who;
        logic [15:0] second_prod;

        Reset = 1'b1; req = 2'b00;
        opa0 = '0; opa1 = '0; opb0 = '0; opb1 = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", 32'({Ld_SB, Clr_XA, Add, Sub, Shift}), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_din", 32'({Din_S, Din_B}), 32'd0);

        // Requester 0: 7 * 3.
        opa0 = 8'd7; opb0 = 8'd3; req = 2'b01;
        push(2'b01, 16'h0015);
        wait_gnt("r0");
        check("load_strobe", 32'(Ld_SB), 32'd1);
        check("load_din", 32'({Din_S, Din_B}), 32'h0703);
        wait_done("r0");
        req = 2'b00;

        // Requester 1: -2 * 3.
        @(negedge Clk);
        opa1 = 8'hFE; opb1 = 8'h03; req = 2'b10;
        push(2'b10, 16'hFFFA);
        wait_done("r1_neg");
        req = 2'b00;

        // Requester 1: 2 * -128, only the final step subtracts.
        @(negedge Clk);
        opa1 = 8'h02; opb1 = 8'h80; req = 2'b10;
        a0 = add_seen; s0 = sub_seen;
        push(2'b10, 16'hFF00);
        wait_done("r1_sub");
        req = 2'b00;
        check("sub_count", 32'(sub_seen - s0), 32'd1);
        check("add_count", 32'(add_seen - a0), 32'd0);

        // Both requesters held: 5*6 for req0, -3*4 for req1.
        @(negedge Clk);
        opa0 = 8'd5; opb0 = 8'd6; opa1 = 8'hFD; opb1 = 8'd4; req = 2'b11;
`ifdef MULT_ARB_ROUND_ROBIN_EN
        second_who = 2'b10; second_prod = 16'hFFF4;
`else
        second_who = 2'b01; second_prod = 16'h001E;
`endif
        third_who = 2'b01;
        push(2'b01, 16'h001E);
        push(second_who, second_prod);
        push(third_who, 16'h001E);
        wait_done("both_1");
        @(negedge Clk);
        check("idle_gap_1", 32'(gnt), 32'd0);
        @(negedge Clk);
        check("grant_2", 32'(gnt), 32'(second_who));
        wait_done("both_2");
        @(negedge Clk);
        check("idle_gap_2", 32'(gnt), 32'd0);
        @(negedge Clk);
        check("grant_3", 32'(gnt), 32'(third_who));
        wait_done("both_3");
        req = 2'b00;

        // Reset in cycle 10 of an operation aborts everything.
        repeat (2) @(negedge Clk);
        opa0 = 8'd9; opb0 = 8'd9; req = 2'b01;
        wait_gnt("rst_mid");
        repeat (9) @(negedge Clk);
        check("mid_gnt_before_rst", 32'(gnt), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_strobes", 32'({Ld_SB, Clr_XA, Add, Sub, Shift}), 32'd0);
        check("mid_rst_product", 32'(product), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_din", 32'({Din_S, Din_B}), 32'd0);
        Reset = 1'b0; req = 2'b00;
        repeat (2) @(negedge Clk);

        // Operands change after LOAD and req drops at cycle 5: 11 * 5 still completes.
        opa0 = 8'h0B; opb0 = 8'h05; req = 2'b01;
        push(2'b01, 16'h0037);
        wait_gnt("hold");
        opa0 = 8'h7F; opb0 = 8'h11;
        repeat (4) @(negedge Clk);
        req = 2'b00;
        check("latched_din", 32'({Din_S, Din_B}), 32'h0B05);
        wait_done("hold");

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
